// File: rtl/raster_pkg.sv
// Shared types and constants for the y-axis scan sequencer.
package raster_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDisplay,
      StReturn,
      StFault
   } scan_state_e;

   localparam int unsigned DefNumRows    = 240;
   localparam int unsigned DefReturnRows = 25;

   localparam logic DirUp   = 1'b0;
   localparam logic DirDown = 1'b1;

endpackage

// File: rtl/y_scan_sequencer_if.sv
// Scan controller signal bundle: strobe/enable in, DAC and laser-gating controls out.
interface y_scan_sequencer_if #(
   parameter int unsigned POS_WIDTH = 8
) ();

   logic                 enable;
   logic                 x_stb_async;
   logic [POS_WIDTH-1:0] y_pos;
   logic                 y_wr;
   logic                 row_valid;
   logic                 frame_start;
   logic                 scan_dir;
   logic                 stb_fault;

   // master = the scan controller, slave = projector side driving strobe/enable
   modport master (
      input  enable, x_stb_async,
      output y_pos, y_wr, row_valid, frame_start, scan_dir, stb_fault
   );

   modport slave (
      output enable, x_stb_async,
      input  y_pos, y_wr, row_valid, frame_start, scan_dir, stb_fault
   );

endinterface

// File: rtl/strobe_sync.sv
// Synchronises the raw opto strobe and emits a one-cycle pulse per rising edge.
module strobe_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic stb_async_i,
   output logic stb_pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   fill_q;
   logic                   last_q;
   logic                   pulse_q;

   // fill_q masks edge detection until the chain holds post-reset samples,
   // so an input already high at reset release is not taken as an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         fill_q  <= '0;
         last_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], stb_async_i};
         fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
         last_q  <= sync_q[SYNC_STAGES-1];
         pulse_q <= fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~last_q;
      end
   end

   assign stb_pulse_o = pulse_q;

endmodule

// File: rtl/y_scan_sequencer.sv
// Vertical scan controller: steps the y DAC once per x-mirror line, with flyback or
// triangle scan, DAC write pulse timing and a missing-strobe watchdog.
module y_scan_sequencer
   import raster_pkg::*;
#(
   parameter int unsigned NUM_ROWS      = DefNumRows,
   parameter int unsigned RETURN_ROWS   = DefReturnRows,
   parameter int unsigned POS_WIDTH     = 8,
   parameter int unsigned BIDIR         = 0,
   parameter int unsigned DAC_WR_CYCLES = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STB_TIMEOUT   = 1048576
) (
   input logic                clk,
   input logic                reset_n,
   y_scan_sequencer_if.master scan_io
);

   localparam int unsigned RetW = $clog2(RETURN_ROWS + 1);
   localparam int unsigned WdW  = $clog2(STB_TIMEOUT + 1);
   localparam int unsigned WrW  = $clog2(DAC_WR_CYCLES + 1);

   localparam logic [POS_WIDTH-1:0] PosOne  = POS_WIDTH'(1);
   localparam logic [POS_WIDTH-1:0] LastRow = POS_WIDTH'(NUM_ROWS - 1);
   localparam logic [RetW-1:0]      RetOne  = RetW'(1);
   localparam logic [RetW-1:0]      RetLast = RetW'(RETURN_ROWS - 1);
   localparam logic [WdW-1:0]       WdOne   = WdW'(1);
   localparam logic [WdW-1:0]       WdLast  = WdW'(STB_TIMEOUT - 1);
   localparam logic [WrW-1:0]       WrOne   = WrW'(1);
   localparam logic [WrW-1:0]       WrLast  = WrW'(DAC_WR_CYCLES - 1);

   logic                 stb_pulse;
   logic                 wd_expired;
   scan_state_e          state_q, state_d;
   logic [POS_WIDTH-1:0] y_pos_q, y_pos_d;
   logic                 row_valid_q, row_valid_d;
   logic                 frame_start_q, frame_start_d;
   logic                 dir_q, dir_d;
   logic                 fault_q, fault_d;
   logic [RetW-1:0]      ret_q, ret_d;
   logic [WdW-1:0]       wd_q, wd_d;
   logic                 upd_q, upd_d;
   logic [WrW-1:0]       wr_cnt_q, wr_cnt_d;
   logic                 y_wr_q, y_wr_d;

   strobe_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_strobe_sync (
      .clk         (clk),
      .reset_n     (reset_n),
      .stb_async_i (scan_io.x_stb_async),
      .stb_pulse_o (stb_pulse)
   );

   // A strobe on the final watchdog count wins over the timeout.
   assign wd_expired = (wd_q == WdLast) && !stb_pulse;

   always_comb begin
      state_d       = state_q;
      y_pos_d       = y_pos_q;
      row_valid_d   = row_valid_q;
      frame_start_d = 1'b0;
      dir_d         = dir_q;
      fault_d       = fault_q;
      ret_d         = ret_q;
      wd_d          = wd_q;

      if (stb_pulse) begin
         wd_d = '0;
      end else if (state_q == StDisplay || state_q == StReturn) begin
         wd_d = wd_q + WdOne;
      end

      unique case (state_q)
         StIdle: begin
            row_valid_d = 1'b0;
            if (stb_pulse && scan_io.enable) begin
               state_d       = StDisplay;
               y_pos_d       = '0;
               dir_d         = DirUp;
               row_valid_d   = 1'b1;
               frame_start_d = 1'b1;
            end
         end
         StDisplay: begin
            if (!scan_io.enable) begin
               state_d     = StIdle;
               row_valid_d = 1'b0;
            end else if (stb_pulse) begin
               if (BIDIR == 0) begin
                  if (y_pos_q == LastRow) begin
                     state_d     = StReturn;
                     y_pos_d     = '0;
                     row_valid_d = 1'b0;
                     ret_d       = '0;
                  end else begin
                     y_pos_d = y_pos_q + PosOne;
                  end
               end else if (dir_q == DirUp) begin
                  if (y_pos_q == LastRow) begin
                     dir_d   = DirDown;
                     y_pos_d = LastRow - PosOne;
                  end else begin
                     y_pos_d = y_pos_q + PosOne;
                  end
               end else begin
                  if (y_pos_q == '0) begin
                     dir_d         = DirUp;
                     y_pos_d       = PosOne;
                     frame_start_d = 1'b1;
                  end else begin
                     y_pos_d = y_pos_q - PosOne;
                  end
               end
            end else if (wd_expired) begin
               state_d     = StFault;
               row_valid_d = 1'b0;
               fault_d     = 1'b1;
            end
         end
         StReturn: begin
            if (!scan_io.enable) begin
               state_d     = StIdle;
               row_valid_d = 1'b0;
            end else if (stb_pulse) begin
               if (ret_q == RetLast) begin
                  state_d       = StDisplay;
                  y_pos_d       = '0;
                  row_valid_d   = 1'b1;
                  frame_start_d = 1'b1;
               end else begin
                  ret_d = ret_q + RetOne;
               end
            end else if (wd_expired) begin
               state_d     = StFault;
               row_valid_d = 1'b0;
               fault_d     = 1'b1;
            end
         end
         StFault: begin
            if (!scan_io.enable) begin
               state_d = StIdle;
               fault_d = 1'b0;
            end
         end
      endcase
   end

   // DAC strobe rises the cycle after y_pos moves; a new move restarts the pulse.
   always_comb begin
      upd_d  = (y_pos_d != y_pos_q);
      y_wr_d = upd_q | (wr_cnt_q != '0);
      if (upd_q) begin
         wr_cnt_d = WrLast;
      end else if (wr_cnt_q != '0) begin
         wr_cnt_d = wr_cnt_q - WrOne;
      end else begin
         wr_cnt_d = wr_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         y_pos_q       <= '0;
         row_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         dir_q         <= DirUp;
         fault_q       <= 1'b0;
         ret_q         <= '0;
         wd_q          <= '0;
         upd_q         <= 1'b0;
         wr_cnt_q      <= '0;
         y_wr_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         y_pos_q       <= y_pos_d;
         row_valid_q   <= row_valid_d;
         frame_start_q <= frame_start_d;
         dir_q         <= dir_d;
         fault_q       <= fault_d;
         ret_q         <= ret_d;
         wd_q          <= wd_d;
         upd_q         <= upd_d;
         wr_cnt_q      <= wr_cnt_d;
         y_wr_q        <= y_wr_d;
      end
   end

   assign scan_io.y_pos       = y_pos_q;
   assign scan_io.y_wr        = y_wr_q;
   assign scan_io.row_valid   = row_valid_q;
   assign scan_io.frame_start = frame_start_q;
   assign scan_io.scan_dir    = dir_q;
   assign scan_io.stb_fault   = fault_q;

endmodule

// File: tb/tb_y_scan_sequencer.sv
// Bench for y_scan_sequencer: a sawtooth instance and a triangle instance share one strobe.
module tb_y_scan_sequencer;

   localparam int MIdle  = 0;
   localparam int MDisp  = 1;
   localparam int MRet   = 2;
   localparam int MFault = 3;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   logic x_stb   = 1'b0;
   logic en      = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   y_scan_sequencer_if #(.POS_WIDTH(8)) if0 ();
   y_scan_sequencer_if #(.POS_WIDTH(8)) if1 ();

   assign if0.enable      = en;
   assign if0.x_stb_async = x_stb;
   assign if1.enable      = en;
   assign if1.x_stb_async = x_stb;

   y_scan_sequencer #(
      .NUM_ROWS      (8),
      .RETURN_ROWS   (3),
      .POS_WIDTH     (8),
      .BIDIR         (0),
      .DAC_WR_CYCLES (4),
      .SYNC_STAGES   (2),
      .STB_TIMEOUT   (64)
   ) u_dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .scan_io (if0)
   );

   y_scan_sequencer #(
      .NUM_ROWS      (4),
      .RETURN_ROWS   (3),
      .POS_WIDTH     (8),
      .BIDIR         (1),
      .DAC_WR_CYCLES (4),
      .SYNC_STAGES   (2),
      .STB_TIMEOUT   (64)
   ) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .scan_io (if1)
   );

   // Reference model state
   int st0 = MIdle, y0 = 0, ret0 = 0, rv0 = 0, exp_fs0 = 0;
   int st1 = MIdle, y1 = 0, d1 = 0, exp_fs1 = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   // Monitor state
   logic       mon_en = 1'b0;
   logic [7:0] prev_y0, prev_y1;
   logic       prev_wr0 = 1'b0;
   logic       chk_wr0 = 1'b0;
   int         hi0 = 0;
   int         fs_act0 = 0, fs_act1 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_step();
      case (st0)
         MIdle: if (en) begin
            st0 = MDisp;
            if (y0 != 0) q0.push_back(8'd0);
            y0 = 0; rv0 = 1; exp_fs0++;
         end
         MDisp: if (y0 == 7) begin
            st0 = MRet; q0.push_back(8'd0); y0 = 0; rv0 = 0; ret0 = 0;
         end else begin
            y0++; q0.push_back(8'(y0));
         end
         MRet: if (ret0 == 2) begin
            st0 = MDisp; rv0 = 1; exp_fs0++;
         end else begin
            ret0++;
         end
         default: ;
      endcase
      case (st1)
         MIdle: if (en) begin
            st1 = MDisp;
            if (y1 != 0) q1.push_back(8'd0);
            y1 = 0; d1 = 0; exp_fs1++;
         end
         MDisp: begin
            if (d1 == 0) begin
               if (y1 == 3) begin d1 = 1; y1 = 2; end
               else y1++;
            end else begin
               if (y1 == 0) begin d1 = 0; y1 = 1; exp_fs1++; end
               else y1--;
            end
            q1.push_back(8'(y1));
         end
         default: ;
      endcase
   endtask

   task automatic strobe(input int gap);
      model_step();
      x_stb = 1'b1;
      step();
      step();
      x_stb = 1'b0;
      repeat (gap - 2) step();
   endtask

   // Scoreboard: every y_pos move must match the next predicted row.
   always @(negedge clk) begin
      logic [7:0] e;
      if (mon_en) begin
         if (chk_wr0) begin
            chk("y_wr_rise", 32'(if0.y_wr), 32'd1);
            chk_wr0 = 1'b0;
         end
         if (if0.y_pos !== prev_y0) begin
            e = (q0.size() != 0) ? q0.pop_front() : prev_y0;
            chk("y_pos0_step", 32'(if0.y_pos), 32'(e));
            hi0 = 0;
            chk_wr0 = 1'b1;
         end else if (if0.y_wr) begin
            hi0++;
         end else if (prev_wr0) begin
            chk("y_wr_width", 32'(hi0), 32'd4);
         end
         if (if1.y_pos !== prev_y1) begin
            e = (q1.size() != 0) ? q1.pop_front() : prev_y1;
            chk("y_pos1_step", 32'(if1.y_pos), 32'(e));
         end
      end else begin
         hi0 = 0;
         chk_wr0 = 1'b0;
      end
      prev_y0  = if0.y_pos;
      prev_y1  = if1.y_pos;
      prev_wr0 = if0.y_wr;
      if (if0.frame_start === 1'b1) fs_act0++;
      if (if1.frame_start === 1'b1) fs_act1++;
   end

   initial begin
      #1;
      reset_n = 1'b0;
      x_stb   = 1'b1;
      en      = 1'b1;
      #2;
      chk("rst_y_pos", 32'(if0.y_pos), 32'd0);
      chk("rst_y_wr", 32'(if0.y_wr), 32'd0);
      chk("rst_row_valid", 32'(if0.row_valid), 32'd0);
      chk("rst_frame_start", 32'(if0.frame_start), 32'd0);
      chk("rst_scan_dir", 32'(if1.scan_dir), 32'd0);
      chk("rst_stb_fault", 32'(if0.stb_fault), 32'd0);
      repeat (3) step();
      reset_n = 1'b1;
      step();
      mon_en = 1'b1;
      // Strobe input held high through reset must not start a frame
      repeat (12) step();
      chk("held_high_rv", 32'(if0.row_valid), 32'(rv0));
      chk("held_high_fs", 32'(fs_act0), 32'(exp_fs0));
      x_stb = 1'b0;
      repeat (5) step();

      for (int i = 0; i < 14; i++) begin
         strobe(40);
         chk("row_valid0", 32'(if0.row_valid), 32'(rv0));
         chk("row_valid1", 32'(if1.row_valid), 32'(st1 == MDisp));
         chk("scan_dir1", 32'(if1.scan_dir), 32'(d1));
         chk("scan_dir0", 32'(if0.scan_dir), 32'd0);
      end
      chk("frame_cnt0", 32'(fs_act0), 32'(exp_fs0));
      chk("frame_cnt1", 32'(fs_act1), 32'(exp_fs1));

      // Two strobe edges three cycles apart: DAC pulse must restart
      model_step();
      x_stb = 1'b1;
      step();
      x_stb = 1'b0;
      step();
      step();
      model_step();
      x_stb = 1'b1;
      step();
      x_stb = 1'b0;
      repeat (38) step();
      chk("restart_y_pos", 32'(if0.y_pos), 32'(y0));

      strobe(40);
      chk("pre_reset_y_pos", 32'(if0.y_pos), 32'd5);

      // Asynchronous reset mid-frame
      mon_en = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_y_pos", 32'(if0.y_pos), 32'd0);
      chk("async_rst_row_valid", 32'(if0.row_valid), 32'd0);
      chk("async_rst_y_wr", 32'(if0.y_wr), 32'd0);
      chk("async_rst_y_pos1", 32'(if1.y_pos), 32'd0);
      repeat (2) step();
      st0 = MIdle; y0 = 0; ret0 = 0; rv0 = 0;
      st1 = MIdle; y1 = 0; d1 = 0;
      q0.delete();
      q1.delete();
      reset_n = 1'b1;
      step();
      mon_en = 1'b1;

      // Next strobe lands exactly on the watchdog's final count
      strobe(64);
      chk("post_rst_row_valid", 32'(if0.row_valid), 32'd1);
      chk("post_rst_frame_cnt", 32'(fs_act0), 32'(exp_fs0));
      model_step();
      x_stb = 1'b1;
      step();
      step();
      x_stb = 1'b0;
      repeat (65) step();
      chk("wd_edge_no_fault0", 32'(if0.stb_fault), 32'd0);
      chk("wd_edge_no_fault1", 32'(if1.stb_fault), 32'd0);
      step();
      chk("wd_fault0", 32'(if0.stb_fault), 32'd1);
      chk("wd_fault_rv0", 32'(if0.row_valid), 32'd0);
      chk("wd_fault_y_pos", 32'(if0.y_pos), 32'(y0));
      chk("wd_fault1", 32'(if1.stb_fault), 32'd1);
      st0 = MFault; rv0 = 0;
      st1 = MFault;

      strobe(20);
      chk("fault_ignores_stb", 32'(if0.y_pos), 32'(y0));
      chk("fault_sticky", 32'(if0.stb_fault), 32'd1);

      en = 1'b0;
      step();
      step();
      chk("fault_clear0", 32'(if0.stb_fault), 32'd0);
      chk("fault_clear1", 32'(if1.stb_fault), 32'd0);
      chk("idle_row_valid", 32'(if0.row_valid), 32'd0);
      st0 = MIdle;
      st1 = MIdle;
      en = 1'b1;
      step();

      strobe(40);
      chk("reenable_row_valid", 32'(if0.row_valid), 32'd1);
      chk("reenable_y_pos", 32'(if0.y_pos), 32'd0);
      chk("reenable_frame_cnt", 32'(fs_act0), 32'(exp_fs0));
      chk("sb0_drained", 32'(q0.size()), 32'd0);
      chk("sb1_drained", 32'(q1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
